// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, pixel colour type and default palette.
// Totals are derived from visible/porch/sync widths so the sync windows fall out of one place.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_FIRST = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
  localparam int V_SYNC_FIRST = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

  localparam int BORDER_W = 10;

  typedef logic [11:0] rgb_t;

  localparam rgb_t DEF_HEAD_RGB   = 12'h0F0;
  localparam rgb_t DEF_BODY_RGB   = 12'h0A0;
  localparam rgb_t DEF_FOOD_RGB   = 12'hF00;
  localparam rgb_t DEF_BORDER_RGB = 12'hFFF;
  localparam rgb_t DEF_BG_RGB     = 12'h000;

endpackage

// File: rtl/vga_scan_compositor_if.sv
// Scan-position / hit-flag / video-pin bundle between the compositor and the hit-test blocks.
// The compositor is the master: it drives the scan counters and video pins and reads the flags back.
interface vga_scan_compositor_if;

  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       snakeHead;
  logic       snakeBody;
  logic       food;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  modport master (
    output xCount, yCount, hsync, vsync, video_on, red, green, blue,
    input  snakeHead, snakeBody, food
  );

  modport slave (
    input  xCount, yCount, hsync, vsync, video_on, red, green, blue,
    output snakeHead, snakeBody, food
  );

endinterface

// File: rtl/vga_timing.sv
// Free-running 800x525 scan counters with combinational sync/active/border decode and frame strobe.
// Decode outputs refer to the counter value of the current cycle; downstream registers them.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk_d,
  input  logic       reset,
  output logic [9:0] xCount,
  output logic [9:0] yCount,
  output logic       hsyncRaw,
  output logic       vsyncRaw,
  output logic       activeRaw,
  output logic       borderRaw,
  output logic       frame_tick
);

  logic [9:0] xCnt;
  logic [9:0] yCnt;
  logic [9:0] xNext;
  logic [9:0] yNext;
  logic       xLast;
  logic       yLast;

  assign xLast = (xCnt == 10'(H_TOTAL - 1));
  assign yLast = (yCnt == 10'(V_TOTAL - 1));

  // yNext is written every cycle, holding its value except on the line wrap.
  always_comb begin
    xNext = xLast ? 10'd0 : xCnt + 10'd1;
    yNext = yCnt;
    if (xLast) begin
      yNext = yLast ? 10'd0 : yCnt + 10'd1;
    end
  end

  always_ff @(posedge clk_d) begin
    if (!reset) begin
      xCnt <= 10'd0;
      yCnt <= 10'd0;
    end else begin
      xCnt <= xNext;
      yCnt <= yNext;
    end
  end

  assign xCount = xCnt;
  assign yCount = yCnt;

  assign hsyncRaw  = !((xCnt >= 10'(H_SYNC_FIRST)) && (xCnt <= 10'(H_SYNC_LAST)));
  assign vsyncRaw  = !((yCnt >= 10'(V_SYNC_FIRST)) && (yCnt <= 10'(V_SYNC_LAST)));
  assign activeRaw = (xCnt < 10'(H_VISIBLE)) && (yCnt < 10'(V_VISIBLE));
  assign borderRaw = activeRaw &&
                     ((xCnt < 10'(BORDER_W)) || (xCnt >= 10'(H_VISIBLE - BORDER_W)) ||
                      (yCnt < 10'(BORDER_W)) || (yCnt >= 10'(V_VISIBLE - BORDER_W)));

  // Start of vertical blank: first pixel of the first invisible line.
  assign frame_tick = (xCnt == 10'd0) && (yCnt == 10'(V_VISIBLE));

endmodule

// File: rtl/vga_scan_compositor.sv
// Composes registered hit flags into RGB aligned with syncs (2 cycles counter-to-pins),
// and divides frame_tick down to the game update strobe while start is high.
module vga_scan_compositor
  import vga_pkg::*;
#(
  parameter int   FRAMES_PER_MOVE = 6,
  parameter rgb_t HEAD_RGB        = DEF_HEAD_RGB,
  parameter rgb_t BODY_RGB        = DEF_BODY_RGB,
  parameter rgb_t FOOD_RGB        = DEF_FOOD_RGB,
  parameter rgb_t BORDER_RGB      = DEF_BORDER_RGB,
  parameter rgb_t BG_RGB          = DEF_BG_RGB
) (
  input  logic                  clk_d,
  input  logic                  reset,
  input  logic                  start,
  vga_scan_compositor_if.master vga,
  output logic                  frame_tick,
  output logic                  update_tick
);

  localparam logic [5:0] LAST_FRAME = 6'(FRAMES_PER_MOVE - 1);

  logic hsyncRaw;
  logic vsyncRaw;
  logic activeRaw;
  logic borderRaw;

  vga_timing uTiming (
    .clk_d      (clk_d),
    .reset      (reset),
    .xCount     (vga.xCount),
    .yCount     (vga.yCount),
    .hsyncRaw   (hsyncRaw),
    .vsyncRaw   (vsyncRaw),
    .activeRaw  (activeRaw),
    .borderRaw  (borderRaw),
    .frame_tick (frame_tick)
  );

  // Stage 1 lines the decode up with the hit flags, which their sources register one cycle late.
  logic hsyncS1;
  logic vsyncS1;
  logic activeS1;
  logic borderS1;
  logic hsyncS2;
  logic vsyncS2;
  logic videoS2;
  rgb_t rgbS2;
  rgb_t pixel;

  always_comb begin
    pixel = BG_RGB;
    if (!activeS1)          pixel = '0;
    else if (vga.snakeHead) pixel = HEAD_RGB;
    else if (vga.snakeBody) pixel = BODY_RGB;
    else if (vga.food)      pixel = FOOD_RGB;
    else if (borderS1)      pixel = BORDER_RGB;
  end

  always_ff @(posedge clk_d) begin
    if (!reset) begin
      hsyncS1  <= 1'b1;
      vsyncS1  <= 1'b1;
      activeS1 <= 1'b0;
      borderS1 <= 1'b0;
      hsyncS2  <= 1'b1;
      vsyncS2  <= 1'b1;
      videoS2  <= 1'b0;
      rgbS2    <= '0;
    end else begin
      hsyncS1  <= hsyncRaw;
      vsyncS1  <= vsyncRaw;
      activeS1 <= activeRaw;
      borderS1 <= borderRaw;
      hsyncS2  <= hsyncS1;
      vsyncS2  <= vsyncS1;
      videoS2  <= activeS1;
      rgbS2    <= pixel;
    end
  end

  assign vga.hsync    = hsyncS2;
  assign vga.vsync    = vsyncS2;
  assign vga.video_on = videoS2;
  assign vga.red      = rgbS2[11:8];
  assign vga.green    = rgbS2[7:4];
  assign vga.blue     = rgbS2[3:0];

  logic [5:0] frameDiv;

  always_ff @(posedge clk_d) begin
    if (!reset || !start) begin
      frameDiv <= 6'd0;
    end else if (frame_tick) begin
      frameDiv <= (frameDiv == LAST_FRAME) ? 6'd0 : frameDiv + 6'd1;
    end
  end

  // Gating with start keeps the strobe quiet in the cycle before the divider clears.
  assign update_tick = start && frame_tick && (frameDiv == LAST_FRAME);

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Directed bench: reset, counter wraps, sync widths, colour priority/alignment, border, divider, mid-frame reset.
// Long vertical stretches are skipped by briefly forcing the line counter inside the timing block.
module tb_vga_scan_compositor;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic frameTick;
  logic updateTick;
  int   checkCount = 0;
  int   passCount  = 0;
  int   width;

  vga_scan_compositor_if vif ();

  vga_scan_compositor dut (
    .clk_d       (clk),
    .reset       (rst),
    .start       (start),
    .vga         (vif),
    .frame_tick  (frameTick),
    .update_tick (updateTick)
  );

  always #20 clk = ~clk;

  function automatic int rgbOut();
    return int'({vif.red, vif.green, vif.blue});
  endfunction

  task automatic checkVal(input string tag, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic waitFor(input int wx, input int wy, input int budget);
    int n = 0;
    while (!(int'(vif.xCount) == wx && int'(vif.yCount) == wy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkVal($sformatf("reach_%0d_%0d", wx, wy),
             int'(int'(vif.xCount) == wx && int'(vif.yCount) == wy), 1);
  endtask

  // Must be called at a negedge where xCount is not 799; leaves yCount at line.
  logic [9:0] skipLine;
  task skipToLine(input logic [9:0] line);
    skipLine = line;
    force dut.uTiming.yCnt = skipLine;
    @(negedge clk);
    release dut.uTiming.yCnt;
  endtask

  task automatic hitPixel(input string tag, input int px, input int py,
                          input logic h, input logic b, input logic f,
                          input int expRgb, input logic expVon);
    waitFor(px + 1, py, 1700);
    checkVal({tag, "_pre"}, rgbOut(), 0);
    vif.snakeHead = h;
    vif.snakeBody = b;
    vif.food      = f;
    @(negedge clk);
    vif.snakeHead = 1'b0;
    vif.snakeBody = 1'b0;
    vif.food      = 1'b0;
    checkVal({tag, "_rgb"}, rgbOut(), expRgb);
    checkVal({tag, "_von"}, int'(vif.video_on), int'(expVon));
    @(negedge clk);
    checkVal({tag, "_after"}, rgbOut(), 0);
  endtask

  task automatic runFrame(input int idx, input logic expUpd);
    skipToLine(10'd479);
    waitFor(0, 480, 900);
    checkVal($sformatf("frame_tick_%0d", idx), int'(frameTick), 1);
    checkVal($sformatf("update_tick_%0d", idx), int'(updateTick), int'(expUpd));
    @(negedge clk);
    checkVal($sformatf("tick_drop_%0d", idx), int'(frameTick | updateTick), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    vif.snakeHead = 1'b0;
    vif.snakeBody = 1'b0;
    vif.food      = 1'b0;

    // Reset state
    @(negedge clk);
    checkVal("rst_x", int'(vif.xCount), 0);
    checkVal("rst_y", int'(vif.yCount), 0);
    checkVal("rst_hsync", int'(vif.hsync), 1);
    checkVal("rst_vsync", int'(vif.vsync), 1);
    checkVal("rst_rgb", rgbOut(), 0);
    checkVal("rst_von", int'(vif.video_on), 0);
    checkVal("rst_ticks", int'(frameTick | updateTick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    checkVal("rel_x0", int'(vif.xCount), 0);
    @(negedge clk);
    checkVal("rel_x1", int'(vif.xCount), 1);
    @(negedge clk);
    checkVal("rel_x2", int'(vif.xCount), 2);

    // Line wrap
    waitFor(799, 0, 900);
    @(negedge clk);
    checkVal("wrap_x", int'(vif.xCount), 0);
    checkVal("wrap_y", int'(vif.yCount), 1);

    // hsync: raw low at 656, pins follow 2 cycles later
    waitFor(656, 1, 900);
    @(negedge clk);
    checkVal("hsync_x657", int'(vif.hsync), 1);
    @(negedge clk);
    checkVal("hsync_x658", int'(vif.hsync), 0);
    width = 0;
    while (vif.hsync == 1'b0 && width < 200) begin
      width++;
      @(negedge clk);
    end
    checkVal("hsync_width", width, 96);

    // Colour priority and 2-cycle alignment on line 100
    skipToLine(10'd99);
    hitPixel("head",  100, 100, 1'b1, 1'b0, 1'b0, 12'h0F0, 1'b1);
    hitPixel("body",  200, 100, 1'b0, 1'b1, 1'b1, 12'h0A0, 1'b1);
    hitPixel("food",  300, 100, 1'b0, 1'b0, 1'b1, 12'hF00, 1'b1);
    hitPixel("all",   400, 100, 1'b1, 1'b1, 1'b1, 12'h0F0, 1'b1);
    hitPixel("blank", 700, 100, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0);

    // Border and background with no flags
    skipToLine(10'd199);
    waitFor(7, 200, 1700);
    checkVal("border_left", rgbOut(), 12'hFFF);
    waitFor(322, 200, 900);
    checkVal("bg_rgb", rgbOut(), 12'h000);
    checkVal("bg_von", int'(vif.video_on), 1);
    waitFor(637, 200, 900);
    checkVal("border_right", rgbOut(), 12'hFFF);

    // vsync: raw low on lines 490..491
    skipToLine(10'd487);
    waitFor(1, 490, 3000);
    checkVal("vsync_pre", int'(vif.vsync), 1);
    @(negedge clk);
    checkVal("vsync_first", int'(vif.vsync), 0);
    width = 0;
    while (vif.vsync == 1'b0 && width < 2000) begin
      width++;
      @(negedge clk);
    end
    checkVal("vsync_width", width, 1600);

    // Frame wrap
    skipToLine(10'd524);
    waitFor(799, 524, 900);
    @(negedge clk);
    checkVal("fwrap_x", int'(vif.xCount), 0);
    checkVal("fwrap_y", int'(vif.yCount), 0);

    // Divider: update on every 6th frame_tick while start
    start = 1'b1;
    for (int i = 1; i <= 8; i++) runFrame(i, i == 6);
    start = 1'b0;
    for (int i = 9; i <= 10; i++) runFrame(i, 1'b0);
    start = 1'b1;
    for (int i = 11; i <= 16; i++) runFrame(i, i == 16);

    // Mid-frame reset
    skipToLine(10'd199);
    waitFor(300, 200, 1700);
    rst = 1'b0;
    @(negedge clk);
    checkVal("mrst_x", int'(vif.xCount), 0);
    checkVal("mrst_y", int'(vif.yCount), 0);
    checkVal("mrst_hsync", int'(vif.hsync), 1);
    checkVal("mrst_vsync", int'(vif.vsync), 1);
    checkVal("mrst_von", int'(vif.video_on), 0);
    checkVal("mrst_rgb", rgbOut(), 0);
    checkVal("mrst_ticks", int'(frameTick | updateTick), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkVal("mrel_x1", int'(vif.xCount), 1);
    checkVal("mrel_y", int'(vif.yCount), 0);
    @(negedge clk);
    checkVal("mrel_x2", int'(vif.xCount), 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
